led_driver: RTL and testbench
=============================

# led_driver

Registered LED output driver: the output end of the board's user-I/O path, where the debounced button front end is the input end. It converts single-cycle event pulses and a static mode select into timed LED patterns: off, steady on, continuous blink, or a counted flash burst. The burst trigger `evt_i` connects directly to the debouncer's rising-edge event output.

## Interface
Parameters:
- `TICK_DIV`, 50000: clock cycles per timebase tick (1 ms at 50 MHz); must be ≥1.
- `ON_TICKS`, 100: ticks per LED-on phase; must be ≥1.
- `OFF_TICKS`, 100: ticks per LED-off phase; must be ≥1.
- `CNT_W`, 4: width of the burst count.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `mode_i` in 2: 0 OFF, 1 ON, 2 BLINK, 3 BURST.
- `evt_i` in 1: one-cycle burst trigger; used only in BURST.
- `count_i` in CNT_W: flashes per burst; sampled with `evt_i`.
- `led_o` out 1: LED drive, registered, active-high.
- `busy_o` out 1: high while a blink or burst sequence is running.
- `done_o` out 1: one-cycle pulse when a burst completes normally.

## Operation
- FSM states: IDLE, ON_PH, OFF_PH.
- The prescaler is held at 0 in IDLE. It runs in ON_PH and OFF_PH, counts 0..TICK_DIV-1, and emits `tick` on the wrap.
- The phase counter is cleared on every state entry and counts ticks.
- OFF: FSM is forced to IDLE; `led_o`=0.
- ON: FSM is forced to IDLE; `led_o`=1.
- BLINK: IDLE goes to ON_PH on the next edge.
  - ON_PH goes to OFF_PH after ON_TICKS ticks.
  - OFF_PH goes to ON_PH after OFF_TICKS ticks.
  - The cycle repeats indefinitely; `done_o` never asserts.
- BURST: in IDLE with `evt_i`=1 and `count_i`≠0, `count_i` is latched into `remain` and the FSM enters ON_PH.
  - ON_PH goes to OFF_PH after ON_TICKS ticks.
  - At the end of OFF_PH, `remain` decrements. If the result is 0, go to IDLE and pulse `done_o`. Otherwise go to ON_PH.
- BURST ignores `evt_i` while busy: no retrigger and no queueing.
- BURST ignores `evt_i` when `count_i`=0.
- `led_o`=1 exactly when state is ON_PH, or when mode is ON.
- `busy_o`=1 exactly when state ≠ IDLE.
- Any change of `mode_i` (compared against a registered copy) aborts the sequence. On the next edge the FSM, prescaler, phase counter and `remain` are cleared, and `done_o` is not pulsed.

## Timing
- Reset values: `led_o`=0, `busy_o`=0, `done_o`=0, state IDLE, all counters 0.
- BURST latency: with `evt_i` sampled at edge k, `led_o` and `busy_o` rise at edge k (state and outputs are registered together).
- ON_PH lasts exactly ON_TICKS×TICK_DIV cycles.
- OFF_PH lasts exactly OFF_TICKS×TICK_DIV cycles.
- A burst of N flashes occupies N×(ON_TICKS+OFF_TICKS)×TICK_DIV cycles. At the final edge, `busy_o` falls and `done_o` rises for one cycle.
- A new `evt_i` in the same cycle that `done_o` is high is ignored. The earliest accepted retrigger is the next cycle.
- If `evt_i` and a mode change occur in the same cycle, the mode change wins and the event is dropped.
- BLINK start: `led_o` rises one edge after `mode_i` becomes BLINK.
- Reset asserted mid-sequence clears all outputs immediately (asynchronous). After release the block is IDLE.
- TICK_DIV=1: a tick occurs every running cycle.

## Structure
- Package `led_pkg` holds:
  - `led_mode_e` (OFF/ON/BLINK/BURST, 2 bits);
  - `led_state_e` (IDLE/ON_PH/OFF_PH);
  - width helper for the counters: prescaler $clog2(TICK_DIV), phase counter $clog2(max(ON_TICKS,OFF_TICKS)+1).
- One sub-module, `led_tick_gen`: prescaler with synchronous clear and enable, producing the `tick` output.
- The top-level module contains the FSM, phase counter, `remain` counter and output registers.

## Test plan
All scenarios use TICK_DIV=4, ON_TICKS=2, OFF_TICKS=3.
- Reset, then mode OFF for 50 cycles → `led_o`=0, `busy_o`=0, `done_o`=0 throughout. Switch to ON → `led_o`=1 next edge.
- BURST with `count_i`=2 and `evt_i` at edge 10 → `led_o` high cycles 10–17 and 30–37, low 18–29 and 38–49. `done_o` pulses at edge 50 with `busy_o` falling.
- BURST busy: extra `evt_i` pulses at edges 15 and 40, plus `evt_i` with `count_i`=0 in IDLE → no change in pattern or `done_o` timing. No start from the zero-count event.
- BLINK for 100 cycles → repeating 8 cycles high, 12 cycles low, starting one edge after the mode change. `done_o` stays 0.
- Mid-burst abort: switch mode to OFF during the second ON phase → `led_o`, `busy_o` = 0 next edge, and no `done_o`. Return to BURST and retrigger → full-length first phase.
- Async reset pulse mid-OFF_PH (not clock-aligned) → outputs 0 immediately. After release, `evt_i` with `count_i`=1 gives 8 high and 12 low cycles, then `done_o`.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and counter-width helpers for the LED output driver.
package led_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    BLINK = 2'd2,
    BURST = 2'd3
  } led_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ON_PH  = 2'd1,
    OFF_PH = 2'd2
  } led_state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned phase_w(input int unsigned on_t, input int unsigned off_t);
    return cnt_w(((on_t > off_t) ? on_t : off_t) + 1);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Timebase prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned PW = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_driver.sv
// LED pattern driver: off, steady on, continuous blink, or counted flash burst.
module led_driver
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned ON_TICKS  = 100,
  parameter int unsigned OFF_TICKS = 100,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       mode_i,
  input  logic             evt_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             led_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned PHW = phase_w(ON_TICKS, OFF_TICKS);
  localparam logic [PHW-1:0] ON_LAST  = PHW'(ON_TICKS - 1);
  localparam logic [PHW-1:0] OFF_LAST = PHW'(OFF_TICKS - 1);

  led_state_e       state_q, state_d;
  logic [PHW-1:0]   ph_q, ph_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       mode_q;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  led_mode_e      mode;
  logic           abort;
  logic           tick;
  logic           phase_end;
  logic [PHW-1:0] ph_last;

  assign mode      = led_mode_e'(mode_i);
  assign abort     = (mode_i != mode_q);
  assign ph_last   = (state_q == ON_PH) ? ON_LAST : OFF_LAST;
  assign phase_end = tick && (ph_q == ph_last);

  // Prescaler sits at zero whenever no sequence is running or one is being aborted.
  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (abort || (state_q == IDLE)),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (abort || (mode == OFF) || (mode == ON)) begin
      state_d = IDLE;
      ph_d    = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          ph_d = '0;
          if (mode == BLINK) begin
            state_d = ON_PH;
          end else if (evt_i && (count_i != '0) && !done_q) begin
            // done_q blocks a retrigger in the completion cycle itself.
            state_d = ON_PH;
            rem_d   = count_i;
          end
        end
        ON_PH: begin
          if (tick) ph_d = ph_q + PHW'(1);
          if (phase_end) begin
            ph_d    = '0;
            state_d = OFF_PH;
          end
        end
        OFF_PH: begin
          if (tick) ph_d = ph_q + PHW'(1);
          if (phase_end) begin
            ph_d    = '0;
            state_d = ON_PH;
            if (mode == BURST) begin
              rem_d = rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          ph_d    = '0;
          rem_d   = '0;
        end
      endcase
    end
    // Outputs derive from the next state so they change on the same edge as the FSM.
    led_d  = (state_d == ON_PH) || (mode == ON);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ph_q    <= '0;
      rem_q   <= '0;
      mode_q  <= 2'd0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      rem_q   <= rem_d;
      mode_q  <= mode_i;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led_o  = led_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_led_driver.sv
// Bench for led_driver: directed scenarios plus random traffic against a timeline model.
module tb_led_driver;
  import led_pkg::*;

  localparam int unsigned TD  = 4;
  localparam int unsigned ONT = 2;
  localparam int unsigned OFT = 3;
  localparam int          ONC = ONT * TD;
  localparam int          PER = (ONT + OFT) * TD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode_i;
  logic       evt_i;
  logic [3:0] count_i;
  logic       led_o, busy_o, done_o;

  int errors = 0;
  int checks = 0;

  // Timeline model: a running sequence is described by its start edge and flash count.
  int         edge_n = 0;
  int         seq = 0;      // 0 none, 1 blink, 2 burst
  int         start = 0;
  int         nfl = 0;
  logic [1:0] mprev = 2'd0;
  bit         done_prev = 1'b0;
  logic       exp_led = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

  led_driver #(
    .TICK_DIV  (TD),
    .ON_TICKS  (ONT),
    .OFF_TICKS (OFT),
    .CNT_W     (4)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .mode_i  (mode_i),
    .evt_i   (evt_i),
    .count_i (count_i),
    .led_o   (led_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d got=%b exp=%b", tag, edge_n, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    seq = 0;
    mprev = 2'd0;
    done_prev = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] m, input logic e, input logic [3:0] c);
    bit ended;
    ended = 1'b0;
    edge_n++;
    if (m != mprev) begin
      seq = 0;
      mprev = m;
    end else begin
      if (seq == 2 && (edge_n - start) == nfl * PER) begin
        seq = 0;
        ended = 1'b1;
      end
      if (m == BLINK && seq == 0) begin
        seq = 1;
        start = edge_n;
      end else if (m == BURST && seq == 0 && !ended && !done_prev && e && c != 0) begin
        seq = 2;
        start = edge_n;
        nfl = int'(c);
      end
    end
    exp_led  = (m == ON) || (seq != 0 && ((edge_n - start) % PER) < ONC);
    exp_busy = (seq != 0);
    exp_done = ended;
    done_prev = ended;
  endtask

  task automatic cyc(input logic [1:0] m, input logic e, input logic [3:0] c);
    mode_i = m;
    evt_i = e;
    count_i = c;
    @(posedge clk);
    model_edge(m, e, c);
    #1;
    chk("led", led_o, exp_led);
    chk("busy", busy_o, exp_busy);
    chk("done", done_o, exp_done);
  endtask

  initial begin
    int k;
    int hi;
    logic [1:0] rm;
    rst_n = 1'b0;
    mode_i = OFF;
    evt_i = 1'b0;
    count_i = 4'd0;
    #12;
    chk("rst_led", led_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    #10 rst_n = 1'b1;
    model_reset();

    // OFF with stray events, then steady ON.
    for (int i = 0; i < 50; i++) cyc(OFF, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    for (int i = 0; i < 5; i++) cyc(ON, 1'($urandom_range(0, 1)), 4'd3);
    cyc(OFF, 1'b0, 4'd0);

    // Burst of two with ignored events while busy and a zero-count event beforehand.
    for (int i = 0; i < 3; i++) cyc(BURST, 1'b0, 4'd0);
    cyc(BURST, 1'b1, 4'd0);
    cyc(BURST, 1'b0, 4'd0);
    chk("zero_count_idle", busy_o, 1'b0);
    cyc(BURST, 1'b1, 4'd2);
    k = 0;
    hi = int'(led_o);
    while (k < 200 && !done_o) begin
      cyc(BURST, (k == 5 || k == 30), 4'd5);
      k++;
      hi += int'(led_o);
    end
    chk_int("burst_len", k, 2 * PER);
    chk_int("burst_hi", hi, 2 * ONC);
    cyc(BURST, 1'b1, 4'd1);
    chk("retrig_in_done", busy_o, 1'b0);
    cyc(BURST, 1'b1, 4'd1);
    chk("retrig_next", busy_o, 1'b1);
    for (int i = 0; i < 25; i++) cyc(BURST, 1'b0, 4'd0);

    // Continuous blink.
    for (int i = 0; i < 100; i++) cyc(BLINK, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    // Abort during the second ON phase, then a fresh burst.
    cyc(BURST, 1'b0, 4'd0);
    cyc(BURST, 1'b0, 4'd0);
    cyc(BURST, 1'b1, 4'd3);
    for (int i = 0; i < 23; i++) cyc(BURST, 1'b0, 4'd0);
    cyc(OFF, 1'b0, 4'd0);
    chk("abort_busy", busy_o, 1'b0);
    for (int i = 0; i < 3; i++) cyc(OFF, 1'b0, 4'd0);
    cyc(BURST, 1'b0, 4'd0);
    cyc(BURST, 1'b1, 4'd2);
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      hi += int'(led_o);
      cyc(BURST, 1'b0, 4'd0);
    end
    chk_int("abort_first_on", hi, ONC);
    for (int i = 0; i < 25; i++) cyc(BURST, 1'b0, 4'd0);

    // Asynchronous reset in the middle of an OFF phase.
    cyc(BURST, 1'b1, 4'd2);
    for (int i = 0; i < 11; i++) cyc(BURST, 1'b0, 4'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_led", led_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_done", done_o, 1'b0);
    #10 rst_n = 1'b1;
    model_reset();
    cyc(BURST, 1'b0, 4'd0);
    cyc(BURST, 1'b1, 4'd1);
    for (int i = 0; i < 25; i++) cyc(BURST, 1'b0, 4'd0);

    // Random traffic with occasional mode changes.
    rm = BURST;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 29) == 0) rm = 2'($urandom_range(0, 3));
      cyc(rm, ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
